// File: rtl/cache_mem_pkg.sv
// Shared cache/main-memory geometry and the main-memory responder state type.
package cache_mem_pkg;

  localparam int ADDR_W      = 32;
  localparam int OFFSET_BITS = 6;
  localparam int INDEX_BITS  = 10;
  localparam int TAG_BITS    = ADDR_W - INDEX_BITS - OFFSET_BITS;
  localparam int BLOCK_W     = 512;
  localparam int WORD_W      = 32;

  typedef enum logic [1:0] {
    MM_IDLE = 2'd0,
    MM_WAIT = 2'd1,
    MM_DONE = 2'd2
  } mm_state_t;

endpackage

// File: rtl/mem_block_store.sv
// Block-wide backing array: one registered block-read port, one word-granular write port.
module mem_block_store #(
  parameter int DEPTH_BLOCKS = 1024,
  parameter int BLOCK_W      = 512,
  parameter int WORD_W       = 32,
  parameter int INDEX_BITS   = 10,
  parameter int WSEL_BITS    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] idx,
  input  logic [WSEL_BITS-1:0]  wsel,
  input  logic [WORD_W-1:0]     wdata,
  output logic [BLOCK_W-1:0]    rdata
);

  logic [BLOCK_W-1:0] mem [DEPTH_BLOCKS];

  // Power-up image: block i holds i in word 0. Reset leaves the array alone.
  initial begin
    for (int i = 0; i < DEPTH_BLOCKS; i++) begin
      mem[i] = BLOCK_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx][wsel*WORD_W +: WORD_W] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/main_mem_responder.sv
// Main-memory responder: one block read or word write at a time, fixed latency,
// single-cycle ready pulse. FSM, latency counter and request latch live here.
module main_mem_responder #(
  parameter int ADDR_W       = 32,
  parameter int BLOCK_W      = 512,
  parameter int WORD_W       = 32,
  parameter int OFFSET_BITS  = 6,
  parameter int DEPTH_BLOCKS = 1024,
  parameter int LATENCY      = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  main_mem_addr,
  input  logic [WORD_W-1:0]  main_mem_data_out,
  input  logic               main_mem_read_req,
  input  logic               main_mem_write_req,
  output logic [BLOCK_W-1:0] main_mem_data_in,
  output logic               main_mem_ready,
  output logic               busy,
  output logic               addr_err
);

  import cache_mem_pkg::mm_state_t;
  import cache_mem_pkg::MM_IDLE;
  import cache_mem_pkg::MM_WAIT;
  import cache_mem_pkg::MM_DONE;

  localparam int IDX_W  = $clog2(DEPTH_BLOCKS);
  localparam int WSEL_W = OFFSET_BITS - 2;
  localparam int HI_LSB = OFFSET_BITS + IDX_W;
  localparam int CNT_W  = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  mm_state_t           state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx_q;
  logic [WSEL_W-1:0]   off_q;
  logic [WORD_W-1:0]   wdata_q;
  logic                is_wr_q;
  logic                err_q;
  logic                req_err;
  logic                accept;
  logic                op_fire;
  logic                st_rd_en;
  logic                st_wr_en;
  logic                unused_addr_lsbs;

  assign unused_addr_lsbs = ^main_mem_addr[1:0];

  // Any set bit above the stored index means the address wrapped.
  generate
    if (HI_LSB < ADDR_W) begin : g_err
      assign req_err = |main_mem_addr[ADDR_W-1:HI_LSB];
    end else begin : g_no_err
      assign req_err = 1'b0;
    end
  endgenerate

  assign accept = (state == MM_IDLE) && (main_mem_read_req || main_mem_write_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= MM_IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        idx_q   <= main_mem_addr[OFFSET_BITS +: IDX_W];
        off_q   <= main_mem_addr[2 +: WSEL_W];
        wdata_q <= main_mem_data_out;
        is_wr_q <= main_mem_write_req;
        err_q   <= req_err;
        cnt     <= CNT_W'(LATENCY);
      end else if (state == MM_WAIT && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MM_IDLE: if (accept) state_nxt = MM_WAIT;
      MM_WAIT: if (cnt == '0) state_nxt = MM_DONE;
      MM_DONE: state_nxt = MM_IDLE;
      default: state_nxt = MM_IDLE;
    endcase
  end

  // All outputs decode registered state, so they behave as flops.
  always_comb begin
    busy           = (state != MM_IDLE);
    main_mem_ready = (state == MM_DONE);
    addr_err       = (state == MM_DONE) && err_q;
    op_fire        = (state == MM_WAIT) && (cnt == '0);
    st_rd_en       = op_fire && !is_wr_q;
    st_wr_en       = op_fire && is_wr_q;
  end

  mem_block_store #(
    .DEPTH_BLOCKS (DEPTH_BLOCKS),
    .BLOCK_W      (BLOCK_W),
    .WORD_W       (WORD_W),
    .INDEX_BITS   (IDX_W),
    .WSEL_BITS    (WSEL_W)
  ) u_store (
    .clk   (clk),
    .rst_n (rst_n),
    .rd_en (st_rd_en),
    .wr_en (st_wr_en),
    .idx   (idx_q),
    .wsel  (off_q),
    .wdata (wdata_q),
    .rdata (main_mem_data_in)
  );

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench for main_mem_responder with hand-computed expected blocks.
module tb_main_mem_responder;

  logic         clk;
  logic         rst_n;
  logic [31:0]  main_mem_addr;
  logic [31:0]  main_mem_data_out;
  logic         main_mem_read_req;
  logic         main_mem_write_req;
  logic [511:0] main_mem_data_in;
  logic         main_mem_ready;
  logic         busy;
  logic         addr_err;

  int checks = 0;
  int errors = 0;

  main_mem_responder dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .main_mem_addr      (main_mem_addr),
    .main_mem_data_out  (main_mem_data_out),
    .main_mem_read_req  (main_mem_read_req),
    .main_mem_write_req (main_mem_write_req),
    .main_mem_data_in   (main_mem_data_in),
    .main_mem_ready     (main_mem_ready),
    .busy               (busy),
    .addr_err           (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, drop it (optionally keep read_req held through WAIT),
  // then check latency, ready width, addr_err and return to idle.
  task automatic request(input string tag, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic hold_rd, input logic exp_err);
    int k;
    main_mem_addr      = addr;
    main_mem_data_out  = data;
    main_mem_read_req  = rd;
    main_mem_write_req = wr;
    tick();
    check({tag, "_busy_after_capture"}, 512'(busy), 512'(1'b1));
    main_mem_write_req = 1'b0;
    main_mem_read_req  = hold_rd;
    main_mem_addr      = 32'hFFFF_FFFC;
    main_mem_data_out  = 32'h5555_5555;
    k = 0;
    while (!main_mem_ready && k < 20) begin
      tick();
      k++;
    end
    check({tag, "_latency"}, 512'(k), 512'(4));
    check({tag, "_addr_err"}, 512'(addr_err), 512'(exp_err));
    check({tag, "_busy_in_done"}, 512'(busy), 512'(1'b1));
    main_mem_read_req = 1'b0;
    tick();
    check({tag, "_ready_one_cycle"}, 512'(main_mem_ready), 512'(1'b0));
    check({tag, "_idle_after"}, 512'(busy), 512'(1'b0));
  endtask

  logic [511:0] exp_blk;
  int           extra_ready;

  initial begin
    rst_n              = 1'b0;
    main_mem_addr      = '0;
    main_mem_data_out  = '0;
    main_mem_read_req  = 1'b0;
    main_mem_write_req = 1'b0;
    #23;
    check("rst_ready", 512'(main_mem_ready), 512'(0));
    check("rst_busy", 512'(busy), 512'(0));
    check("rst_err", 512'(addr_err), 512'(0));
    check("rst_data", main_mem_data_in, 512'(0));
    rst_n = 1'b1;
    tick();
    tick();

    // Read block 64.
    request("rd_1000", 1'b1, 1'b0, 32'h0000_1000, 32'h0, 1'b0, 1'b0);
    check("rd_1000_data", main_mem_data_in, 512'h40);

    // Reset mid-sim clears outputs; no spurious ready afterwards.
    rst_n = 1'b0;
    #1;
    check("rst2_data", main_mem_data_in, 512'(0));
    check("rst2_busy", 512'(busy), 512'(0));
    check("rst2_ready", 512'(main_mem_ready), 512'(0));
    tick();
    rst_n = 1'b1;
    extra_ready = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (main_mem_ready || busy) extra_ready++;
    end
    check("rst2_no_spurious", 512'(extra_ready), 512'(0));

    // Write word 1 of block 128, then read it back.
    request("wr_2004", 1'b0, 1'b1, 32'h0000_2004, 32'hCAFE_BABE, 1'b0, 1'b0);
    check("wr_2004_data_unchanged", main_mem_data_in, 512'(0));
    request("rd_2000", 1'b1, 1'b0, 32'h0000_2000, 32'h0, 1'b0, 1'b0);
    exp_blk = '0;
    exp_blk[31:0]  = 32'h80;
    exp_blk[63:32] = 32'hCAFE_BABE;
    check("rd_2000_data", main_mem_data_in, exp_blk);

    // Read+write together: write wins; read held during WAIT/DONE is ignored.
    request("rw_2000", 1'b1, 1'b1, 32'h0000_2000, 32'h1234_5678, 1'b1, 1'b0);
    extra_ready = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (main_mem_ready || busy) extra_ready++;
    end
    check("rw_no_second_ready", 512'(extra_ready), 512'(0));
    check("rw_data_unchanged", main_mem_data_in, exp_blk);
    request("rd_2000b", 1'b1, 1'b0, 32'h0000_2000, 32'h0, 1'b0, 1'b0);
    exp_blk[31:0] = 32'h1234_5678;
    check("rd_2000b_data", main_mem_data_in, exp_blk);

    // Reset two cycles after capturing a write aborts it.
    main_mem_addr      = 32'h0000_3000;
    main_mem_data_out  = 32'hDEAD_BEEF;
    main_mem_write_req = 1'b1;
    tick();
    main_mem_write_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("rstw_busy", 512'(busy), 512'(0));
    check("rstw_data", main_mem_data_in, 512'(0));
    tick();
    rst_n = 1'b1;
    tick();
    request("rd_3000", 1'b1, 1'b0, 32'h0000_3000, 32'h0, 1'b0, 1'b0);
    check("rd_3000_data", main_mem_data_in, 512'hC0);
    request("rd_2000c", 1'b1, 1'b0, 32'h0000_2000, 32'h0, 1'b0, 1'b0);
    check("rd_2000c_kept", main_mem_data_in, exp_blk);

    // Wrapped address: block 1025 aliases block 1 and flags addr_err.
    request("rd_wrap", 1'b1, 1'b0, 32'h0001_0040, 32'h0, 1'b0, 1'b1);
    check("rd_wrap_data", main_mem_data_in, 512'h1);
    request("rd_inrange", 1'b1, 1'b0, 32'h0000_1000, 32'h0, 1'b0, 1'b0);
    check("rd_inrange_data", main_mem_data_in, 512'h40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
